dmem_banked: RTL and testbench

Parametrised single-port data memory for the pipelined CPU's MEM stage. It replaces the fixed 8-entry word memory with a byte-addressed array of configurable depth. Requests use a valid/ready handshake and support byte-lane stores, sign- or zero-extended byte loads, and a registered read path of configurable latency. After reset, a clear sequencer zeroes the array before any request is accepted.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_rd_pipe.sv | 36 +++
 rtl/dmem_banked.sv | 127 ++++++++++++
 tb/tb_dmem_banked.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM states and byte-extend helper for the data memory
package dmem_pkg;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  // Per-load context carried down the read pipe; rej forces a zero result.
  typedef struct packed {
    logic [15:0] data;
    logic        lane;
    logic        size;
    logic        sgn;
    logic        rej;
  } rd_info_t;

  function automatic logic [15:0] byte_extend(input logic [7:0] b, input logic sgn);
    return {{8{sgn & b[7]}}, b};
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// rtl/dmem_rd_pipe.sv - RD_LAT-stage valid/context shift register for the load path
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  rd_info_t in_info,
  output logic     out_valid,
  output rd_info_t out_info
);

  logic [RD_LAT-1:0] vld;
  rd_info_t          stg [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  // Context needs no reset: it is only consumed alongside its valid bit.
  always_ff @(posedge clk) begin
    stg[0] <= in_info;
    for (int i = 1; i < RD_LAT; i++) stg[i] <= stg[i-1];
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_info  = stg[RD_LAT-1];

endmodule

// File: rtl/dmem_banked.sv
// rtl/dmem_banked.sv - byte-addressed MEM-stage data memory with clear sequencer; DMEM_MISALIGN_TRAP_EN traps odd word accesses
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err,
  output logic              init_busy
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int PTR_W = $clog2(DEPTH);

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [PTR_W-1:0]  widx;
  logic              lane, oor, mis, rej, acc;
  logic              err_pend;
  logic              rd_out_valid;
  rd_info_t          rd_in, rd_out;
  logic [DATA_W-1:0] ext;

  assign idx  = req_addr[ADDR_W-1:1];
  assign widx = idx[PTR_W-1:0];
  assign lane = req_addr[0];
  assign oor  = idx >= IDX_W'(DEPTH);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (req_size == SZ_WORD) && lane;
`else
  assign mis = 1'b0;
`endif

  assign rej = oor | mis;
  assign acc = req_valid && req_ready && rst;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    init_busy = 1'b0;
    case (state)
      ST_CLEAR: begin
        init_busy = 1'b1;
        if (clr_ptr == PTR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: req_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (acc && req_we && !rej) begin
      if (req_size == SZ_WORD) mem[widx] <= req_wdata;
      else if (lane)           mem[widx][15:8] <= req_wdata[7:0];
      else                     mem[widx][7:0]  <= req_wdata[7:0];
    end
  end

  // Array is read in the accept cycle, so a store one edge earlier is already visible.
  always_comb begin
    rd_in.data = mem[widx];
    rd_in.lane = lane;
    rd_in.size = req_size;
    rd_in.sgn  = req_signed;
    rd_in.rej  = rej;
  end

  dmem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc && !req_we),
    .in_info   (rd_in),
    .out_valid (rd_out_valid),
    .out_info  (rd_out)
  );

  always_comb begin
    ext = '0;
    if (!rd_out.rej) begin
      if (rd_out.size == SZ_WORD) ext = rd_out.data;
      else ext = byte_extend(rd_out.lane ? rd_out.data[15:8] : rd_out.data[7:0], rd_out.sgn);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err_pend  <= 1'b0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= rd_out_valid;
      if (rd_out_valid) rsp_data <= ext;
      err_pend <= acc && rej;
      err      <= err_pend;
    end
  end

endmodule

// File: tb/tb_dmem_banked.sv
// tb/tb_dmem_banked.sv - self-checking bench for dmem_banked against a byte-array reference model
module tb_dmem_banked;

  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_size, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, err, init_busy;
  logic [15:0] rsp_data;

  always #5 clk = ~clk;

  dmem_banked #(.DATA_W(16), .DEPTH(DEPTH), .ADDR_W(16), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .err        (err),
    .init_busy  (init_busy)
  );

  typedef struct {
    bit          we;
    bit          sz;
    bit          sg;
    logic [15:0] addr;
    logic [15:0] wd;
  } req_t;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mb [2*DEPTH];
  req_t        rq [$];
  bit          ev_rsp  [512];
  bit          ev_err  [512];
  logic [15:0] ev_data [512];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input bit we, input bit sz, input bit sg,
                              input logic [15:0] a, input logic [15:0] wd);
    req_t r;
    r.we = we; r.sz = sz; r.sg = sg; r.addr = a; r.wd = wd;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2*DEPTH; i++) mb[i] = 8'h00;
  endtask

  // Memory viewed as plain little-endian bytes; words are pairs of bytes.
  task automatic model(input req_t r, output bit e, output logic [15:0] d);
    int wi, v;
    bit rj;
    wi = int'(r.addr) / 2;
    rj = (wi >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (r.sz && r.addr[0]) rj = 1'b1;
`endif
    e = rj;
    d = 16'h0000;
    if (r.we) begin
      if (!rj) begin
        if (r.sz) begin
          mb[2*wi]   = r.wd[7:0];
          mb[2*wi+1] = r.wd[15:8];
        end else begin
          mb[int'(r.addr)] = r.wd[7:0];
        end
      end
    end else if (!rj) begin
      if (r.sz) begin
        d = {mb[2*wi+1], mb[2*wi]};
      end else begin
        v = int'(mb[int'(r.addr)]);
        if (r.sg && v >= 128) v = v - 256;
        d = 16'(v);
      end
    end
  endtask

  task automatic wait_clear();
    int cnt;
    cnt = 0;
    while (init_busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("clear_cycles", 16'(cnt), 16'd32);
    chk("ready_after_clear", {15'b0, req_ready}, 16'h0001);
  endtask

  // Issues the queued requests on consecutive cycles and checks every cycle's outputs.
  task automatic run();
    int n;
    n = rq.size();
    for (int k = 0; k < n + LAT + 3; k++) begin
      ev_rsp[k] = 1'b0; ev_err[k] = 1'b0; ev_data[k] = 16'h0;
    end
    for (int k = 0; k < n + LAT + 3; k++) begin
      req_t        r;
      bit          e;
      logic [15:0] d;
      @(negedge clk);
      chk("rsp_valid", {15'b0, rsp_valid}, {15'b0, ev_rsp[k]});
      if (ev_rsp[k]) chk("rsp_data", rsp_data, ev_data[k]);
      chk("err", {15'b0, err}, {15'b0, ev_err[k]});
      if (k < n) begin
        r = rq[k];
        chk("req_ready", {15'b0, req_ready}, 16'h0001);
        req_valid  = 1'b1;
        req_we     = r.we;
        req_size   = r.sz;
        req_signed = r.sg;
        req_addr   = r.addr;
        req_wdata  = r.wd;
        model(r, e, d);
        ev_err[k+2] = e;
        if (!r.we) begin
          ev_rsp[k+LAT+1]  = 1'b1;
          ev_data[k+LAT+1] = d;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    rq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {15'b0, req_ready}, 16'h0000);
    chk("reset_rsp_valid", {15'b0, rsp_valid}, 16'h0000);
    chk("reset_rsp_data", rsp_data, 16'h0000);
    chk("reset_err", {15'b0, err}, 16'h0000);
    chk("reset_init_busy", {15'b0, init_busy}, 16'h0001);
    rst = 1'b1;
    wait_clear();
    clear_model();

    rq.push_back(mk(0, 1, 0, 16'h0006, 16'h0));
    run();

    rq.push_back(mk(1, 1, 0, 16'h0006, 16'hBEDE));
    rq.push_back(mk(1, 0, 0, 16'h0007, 16'h0012));
    rq.push_back(mk(0, 1, 0, 16'h0006, 16'h0));
    run();

    rq.push_back(mk(1, 1, 0, 16'h0008, 16'h80FF));
    rq.push_back(mk(0, 0, 1, 16'h0009, 16'h0));
    rq.push_back(mk(0, 0, 0, 16'h0008, 16'h0));
    rq.push_back(mk(0, 0, 1, 16'h0008, 16'h0));
    run();

    rq.push_back(mk(1, 1, 0, 16'h0040, 16'hA5A5));
    rq.push_back(mk(0, 1, 0, 16'h0040, 16'h0));
    rq.push_back(mk(0, 1, 0, 16'h0003, 16'h0));
    rq.push_back(mk(1, 1, 0, 16'h003F, 16'h1357));
    rq.push_back(mk(0, 1, 0, 16'h003E, 16'h0));
    run();

    for (int i = 0; i < 4; i++) rq.push_back(mk(1, 1, 0, 16'(2*i + 16), 16'($urandom)));
    for (int i = 0; i < 4; i++) rq.push_back(mk(0, 1, 0, 16'(2*i + 16), 16'h0));
    run();

    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 50; i++)
        rq.push_back(mk(1'($urandom), 1'($urandom), 1'($urandom),
                        16'($urandom_range(0, 2*DEPTH + 9)), 16'($urandom)));
      run();
    end

    rq.push_back(mk(1, 1, 0, 16'h0002, 16'h5555));
    run();
    @(negedge clk);
    chk("midrst_ready", {15'b0, req_ready}, 16'h0001);
    req_valid = 1'b1; req_we = 1'b0; req_size = 1'b1; req_addr = 16'h0002;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_rsp_valid", {15'b0, rsp_valid}, 16'h0000);
      chk("midrst_init_busy", {15'b0, init_busy}, 16'h0001);
    end
    rst = 1'b1;
    wait_clear();
    clear_model();
    rq.push_back(mk(0, 1, 0, 16'h0002, 16'h0));
    run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
